// File: rtl/axi_tdd_ng_frame_seq.sv
// ---------------------------------------------------------------------------
// axi_tdd_ng_frame_seq
//
// Frame sequencer for the TDD engine. It waits for a sync pulse, optionally
// runs a startup delay, then counts frames of tdd_frame_length cycles. A burst
// of tdd_burst_count frames returns the sequencer to ARMED. A burst count of 0
// means the frames run without end.
//
// Ports
//   clk, resetn         clock and synchronous active-low reset
//   tdd_enable          run enable. When low, the block returns to IDLE and
//                       clears its counters.
//   tdd_sync            one-cycle sync pulse from the sync generator
//   tdd_sync_rst        when set, a sync seen while RUNNING restarts the frame
//                       and the burst
//   tdd_startup_delay   cycles from sync to the first frame (0 = no delay)
//   tdd_frame_length    frame length in cycles (0 is treated as 1)
//   tdd_burst_count     frames per burst (0 = infinite)
//   tdd_counter         position inside the current delay or frame
//   tdd_cstate          FSM state: 0 IDLE, 1 ARMED, 2 DELAY, 3 RUNNING
//   tdd_tstart          one-cycle pulse on the first RUNNING cycle
//   tdd_endof_frame     high on the last cycle of each frame
//   tdd_burst_done      one-cycle pulse on the cycle after ARMED is re-entered
//                       at the end of a burst
//
// Config inputs are used live. Software changes them only while tdd_enable is
// low. There is no glitch protection for changes made during a run.
// ---------------------------------------------------------------------------
module axi_tdd_ng_frame_seq #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync,
  input  logic                         tdd_sync_rst,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output logic [1:0]                   tdd_cstate,
  output logic                         tdd_tstart,
  output logic                         tdd_endof_frame,
  output logic                         tdd_burst_done
);

  localparam logic [REGISTER_WIDTH-1:0]    ONE_RW =
    {{(REGISTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_COUNT_WIDTH-1:0] ONE_BC =
    {{(BURST_COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DELAY   = 2'd2,
    ST_RUNNING = 2'd3
  } state_t;

  state_t                         state;
  logic [REGISTER_WIDTH-1:0]      counter;
  logic [BURST_COUNT_WIDTH-1:0]   frame_cnt;   // frames completed in this burst
  logic                           tstart;
  logic                           burst_pend;  // burst ended on the last edge
  logic                           burst_done;

  // Decode of the registered state and counter against the live config.
  logic [REGISTER_WIDTH-1:0]      frame_last;
  logic                           delay_done;
  logic                           eof_hit;
  logic                           burst_last;
  logic                           frame_sat;
  logic                           sync_restart;

  // A frame length of 0 behaves like 1, so the last index is 0 in both cases.
  assign frame_last = (tdd_frame_length == '0) ? '0 : (tdd_frame_length - ONE_RW);

  // This uses >= rather than ==. If the delay shrinks mid-count, the counter
  // still leaves DELAY and does not run until it wraps.
  assign delay_done = (tdd_startup_delay == '0) ||
                      (counter >= (tdd_startup_delay - ONE_RW));

  assign eof_hit    = (state == ST_RUNNING) && (counter == frame_last);

  // The frame that is ending has 1-based number frame_cnt+1. A saturated count
  // only happens with burst_count 0. Its +1 wraps to 0, which cannot match a
  // nonzero burst count.
  assign burst_last = (tdd_burst_count != '0) &&
                      ((frame_cnt + ONE_BC) == tdd_burst_count);

  assign frame_sat  = &frame_cnt;

  assign sync_restart = tdd_sync && tdd_sync_rst;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      counter    <= '0;
      frame_cnt  <= '0;
      tstart     <= 1'b0;
      burst_pend <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      // Pulses default low. burst_done trails the return to ARMED by one cycle.
      tstart     <= 1'b0;
      burst_pend <= 1'b0;
      burst_done <= burst_pend;

      if (!tdd_enable) begin
        state      <= ST_IDLE;
        counter    <= '0;
        frame_cnt  <= '0;
        burst_done <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            counter   <= '0;
            frame_cnt <= '0;
            state     <= ST_ARMED;
          end

          ST_ARMED: begin
            counter   <= '0;
            frame_cnt <= '0;
            if (tdd_sync) begin
              if (tdd_startup_delay == '0) begin
                state  <= ST_RUNNING;
                tstart <= 1'b1;
              end else begin
                state  <= ST_DELAY;
              end
            end
          end

          // A sync pulse is ignored while the startup delay runs.
          ST_DELAY: begin
            if (delay_done) begin
              state   <= ST_RUNNING;
              counter <= '0;
              tstart  <= 1'b1;
            end else begin
              counter <= counter + ONE_RW;
            end
          end

          ST_RUNNING: begin
            if (sync_restart) begin
              // A restart wins over an end of frame on the same cycle. The
              // frame does not count, and tstart is not pulsed again.
              counter   <= '0;
              frame_cnt <= '0;
            end else if (eof_hit) begin
              counter <= '0;
              if (burst_last) begin
                state      <= ST_ARMED;
                frame_cnt  <= '0;
                burst_pend <= 1'b1;
              end else if (!frame_sat) begin
                frame_cnt <= frame_cnt + ONE_BC;
              end
            end else begin
              counter <= counter + ONE_RW;
            end
          end

          default: begin
            state   <= ST_IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

  assign tdd_counter     = counter;
  assign tdd_cstate      = state;
  assign tdd_tstart      = tstart;
  assign tdd_endof_frame = eof_hit;
  assign tdd_burst_done  = burst_done;

endmodule
